// File: rtl/can_rx_drain.sv
// can_rx_drain: APB master that drains the PeliCAN receive buffer of an
// SJA1000 controller wrapper. On an RX interrupt it reads IR, the frame
// information byte, the ID bytes and the data bytes. It then releases the
// buffer with RRB and presents the frame on a valid/ready stream.
// Optional macro CAN_DRAIN_TIMEOUT_EN: aborts a transfer whose pready stays
// low for TIMEOUT_CYCLES access cycles, treating it like a slave error.
module can_rx_drain #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned CMD_REG        = 32'd1,
  parameter int unsigned IR_REG         = 32'd3,
  parameter int unsigned RXBUF_REG      = 32'd16,
  parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
  input  logic        aclk,
  input  logic        arstn,
  input  logic        enable_i,
  input  logic        irq_i,
  output logic [31:0] m_apb_paddr,
  output logic        m_apb_psel,
  output logic        m_apb_penable,
  output logic        m_apb_pwrite,
  output logic [31:0] m_apb_pwdata,
  output logic [3:0]  m_apb_pstrb,
  output logic [2:0]  m_apb_pprot,
  input  logic [31:0] m_apb_prdata,
  input  logic        m_apb_pready,
  input  logic        m_apb_pslverr,
  output logic        frm_valid_o,
  input  logic        frm_ready_i,
  output logic        frm_ide_o,
  output logic        frm_rtr_o,
  output logic [28:0] frm_id_o,
  output logic [3:0]  frm_dlc_o,
  output logic [63:0] frm_data_o,
  output logic        ir_valid_o,
  output logic [7:0]  ir_value_o,
  output logic        err_o,
  input  logic        err_clr_i
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_IR   = 3'd1,
    S_RD_FI   = 3'd2,
    S_RD_ID   = 3'd3,
    S_RD_DATA = 3'd4,
    S_WR_CMD  = 3'd5,
    S_OUT     = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic        psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        pwrite_q, pwrite_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic [3:0]  pstrb_q, pstrb_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        ide_q, ide_d;
  logic        rtr_q, rtr_d;
  logic [3:0]  dlc_q, dlc_d;
  logic [28:0] id_q, id_d;
  logic [63:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        ir_valid_q, ir_valid_d;
  logic [7:0]  ir_value_q, ir_value_d;
  logic        err_q, err_d;

  logic [3:0]  nb_s;
  logic [31:0] idx_s;
  logic [7:0]  rd_byte_s;
  logic        err_set_s;
  logic        tmo_hit_s;
  logic        unused_prdata_s;

  // Only the low byte of the read bus carries controller register data.
  assign rd_byte_s       = m_apb_prdata[7:0];
  assign unused_prdata_s = ^m_apb_prdata[31:8];

`ifdef CAN_DRAIN_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;

  // Wait-state counter: cleared in SETUP, counts ACCESS cycles without pready.
  always_comb begin
    tmo_d = tmo_q;
    if (psel_q && !penable_q) begin
      tmo_d = 16'd0;
    end else if (psel_q && penable_q && !m_apb_pready) begin
      tmo_d = tmo_q + 16'd1;
    end else begin
      tmo_d = tmo_q;
    end
  end

  // Timeout fires on the access cycle that brings the wait count to the limit.
  always_comb begin
    tmo_hit_s = psel_q && penable_q && !m_apb_pready &&
                (({16'd0, tmo_q} + 32'd1) >= TIMEOUT_CYCLES);
  end

  // Wait-state counter register.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      tmo_q <= 16'd0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_tmo_s;
  assign unused_tmo_s = (TIMEOUT_CYCLES == 32'd0);
  assign tmo_hit_s    = 1'b0;
`endif

  // Number of data bytes to fetch: none for remote frames, DLC clamped to 8.
  always_comb begin
    nb_s = 4'd0;
    if (rtr_q) begin
      nb_s = 4'd0;
    end else if (dlc_q > 4'd8) begin
      nb_s = 4'd8;
    end else begin
      nb_s = dlc_q;
    end
  end

  // Register index addressed by the transfer of the current state.
  always_comb begin
    idx_s = 32'd0;
    case (state_q)
      S_RD_IR:   idx_s = IR_REG;
      S_RD_FI:   idx_s = RXBUF_REG;
      S_RD_ID:   idx_s = RXBUF_REG + 32'd1 + {29'd0, cnt_q};
      S_RD_DATA: begin
        if (ide_q) begin
          idx_s = RXBUF_REG + 32'd5 + {29'd0, cnt_q};
        end else begin
          idx_s = RXBUF_REG + 32'd3 + {29'd0, cnt_q};
        end
      end
      S_WR_CMD:  idx_s = CMD_REG;
      default:   idx_s = 32'd0;
    endcase
  end

  // Next-state, APB sequencing and frame capture.
  always_comb begin
    state_d    = state_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    pstrb_d    = pstrb_q;
    cnt_d      = cnt_q;
    ide_d      = ide_q;
    rtr_d      = rtr_q;
    dlc_d      = dlc_q;
    id_d       = id_q;
    data_d     = data_q;
    valid_d    = valid_q;
    ir_valid_d = 1'b0;
    ir_value_d = ir_value_q;
    err_set_s  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (irq_i && enable_i) begin
          state_d = S_RD_IR;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_OUT: begin
        if (frm_ready_i) begin
          valid_d = 1'b0;
          state_d = S_RD_IR;
        end else begin
          valid_d = 1'b1;
        end
      end

      S_RD_IR, S_RD_FI, S_RD_ID, S_RD_DATA, S_WR_CMD: begin
        if (!psel_q) begin
          // Idle gap (or first cycle of the step): launch SETUP next cycle.
          psel_d    = 1'b1;
          penable_d = 1'b0;
          paddr_d   = BASE_ADDR + (idx_s << 2'd2);
          if (state_q == S_WR_CMD) begin
            pwrite_d = 1'b1;
            pwdata_d = 32'h0000_0004;
            pstrb_d  = 4'b0001;
          end else begin
            pwrite_d = 1'b0;
            pwdata_d = 32'h0000_0000;
            pstrb_d  = 4'b0000;
          end
        end else if (!penable_q) begin
          penable_d = 1'b1;
        end else if (m_apb_pready) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          if (m_apb_pslverr) begin
            err_set_s = 1'b1;
            state_d   = S_IDLE;
          end else begin
            case (state_q)
              S_RD_IR: begin
                ir_valid_d = 1'b1;
                ir_value_d = rd_byte_s;
                if (rd_byte_s[0]) begin
                  data_d  = 64'd0;
                  id_d    = 29'd0;
                  cnt_d   = 3'd0;
                  state_d = S_RD_FI;
                end else begin
                  state_d = S_IDLE;
                end
              end
              S_RD_FI: begin
                ide_d   = rd_byte_s[7];
                rtr_d   = rd_byte_s[6];
                dlc_d   = rd_byte_s[3:0];
                cnt_d   = 3'd0;
                state_d = S_RD_ID;
              end
              S_RD_ID: begin
                case ({ide_q, cnt_q[1:0]})
                  3'b000:  id_d[10:3]  = rd_byte_s;
                  3'b001:  id_d[2:0]   = rd_byte_s[7:5];
                  3'b100:  id_d[28:21] = rd_byte_s;
                  3'b101:  id_d[20:13] = rd_byte_s;
                  3'b110:  id_d[12:5]  = rd_byte_s;
                  3'b111:  id_d[4:0]   = rd_byte_s[7:3];
                  default: id_d        = id_q;
                endcase
                if ((ide_q && cnt_q == 3'd3) || (!ide_q && cnt_q == 3'd1)) begin
                  cnt_d = 3'd0;
                  if (nb_s == 4'd0) begin
                    state_d = S_WR_CMD;
                  end else begin
                    state_d = S_RD_DATA;
                  end
                end else begin
                  cnt_d = cnt_q + 3'd1;
                end
              end
              S_RD_DATA: begin
                data_d[{cnt_q, 3'b000} +: 8] = rd_byte_s;
                if ({1'b0, cnt_q} == (nb_s - 4'd1)) begin
                  cnt_d   = 3'd0;
                  state_d = S_WR_CMD;
                end else begin
                  cnt_d = cnt_q + 3'd1;
                end
              end
              S_WR_CMD: begin
                valid_d = 1'b1;
                state_d = S_OUT;
              end
              default: state_d = S_IDLE;
            endcase
          end
        end else if (tmo_hit_s) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          err_set_s = 1'b1;
          state_d   = S_IDLE;
        end else begin
          penable_d = 1'b1;
        end
      end

      default: begin
        state_d   = S_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        valid_d   = 1'b0;
      end
    endcase

    // A new error takes priority over a simultaneous clear request.
    if (err_set_s) begin
      err_d = 1'b1;
    end else if (err_clr_i) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // State and output registers; reset drops the bus cycle immediately.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state_q    <= S_IDLE;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= 32'd0;
      pwdata_q   <= 32'd0;
      pstrb_q    <= 4'd0;
      cnt_q      <= 3'd0;
      ide_q      <= 1'b0;
      rtr_q      <= 1'b0;
      dlc_q      <= 4'd0;
      id_q       <= 29'd0;
      data_q     <= 64'd0;
      valid_q    <= 1'b0;
      ir_valid_q <= 1'b0;
      ir_value_q <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      pstrb_q    <= pstrb_d;
      cnt_q      <= cnt_d;
      ide_q      <= ide_d;
      rtr_q      <= rtr_d;
      dlc_q      <= dlc_d;
      id_q       <= id_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ir_valid_q <= ir_valid_d;
      ir_value_q <= ir_value_d;
      err_q      <= err_d;
    end
  end

  assign m_apb_paddr   = paddr_q;
  assign m_apb_psel    = psel_q;
  assign m_apb_penable = penable_q;
  assign m_apb_pwrite  = pwrite_q;
  assign m_apb_pwdata  = pwdata_q;
  assign m_apb_pstrb   = pstrb_q;
  assign m_apb_pprot   = 3'b000;
  assign frm_valid_o   = valid_q;
  assign frm_ide_o     = ide_q;
  assign frm_rtr_o     = rtr_q;
  assign frm_id_o      = id_q;
  assign frm_dlc_o     = dlc_q;
  assign frm_data_o    = data_q;
  assign ir_valid_o    = ir_valid_q;
  assign ir_value_o    = ir_value_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_can_rx_drain.sv
// Bench for can_rx_drain: behavioural APB slave standing in for the SJA1000
// register file, plus scoreboards for APB transfers, IR reads and frames.
module tb_can_rx_drain;

  logic        aclk;
  logic        arstn;
  logic        enable_i;
  logic        irq_i;
  logic [31:0] m_apb_paddr;
  logic        m_apb_psel;
  logic        m_apb_penable;
  logic        m_apb_pwrite;
  logic [31:0] m_apb_pwdata;
  logic [3:0]  m_apb_pstrb;
  logic [2:0]  m_apb_pprot;
  logic [31:0] m_apb_prdata;
  logic        m_apb_pready;
  logic        m_apb_pslverr;
  logic        frm_valid_o;
  logic        frm_ready_i;
  logic        frm_ide_o;
  logic        frm_rtr_o;
  logic [28:0] frm_id_o;
  logic [3:0]  frm_dlc_o;
  logic [63:0] frm_data_o;
  logic        ir_valid_o;
  logic [7:0]  ir_value_o;
  logic        err_o;
  logic        err_clr_i;

  can_rx_drain #(.TIMEOUT_CYCLES(32'd10)) dut (
    .aclk(aclk), .arstn(arstn), .enable_i(enable_i), .irq_i(irq_i),
    .m_apb_paddr(m_apb_paddr), .m_apb_psel(m_apb_psel),
    .m_apb_penable(m_apb_penable), .m_apb_pwrite(m_apb_pwrite),
    .m_apb_pwdata(m_apb_pwdata), .m_apb_pstrb(m_apb_pstrb),
    .m_apb_pprot(m_apb_pprot), .m_apb_prdata(m_apb_prdata),
    .m_apb_pready(m_apb_pready), .m_apb_pslverr(m_apb_pslverr),
    .frm_valid_o(frm_valid_o), .frm_ready_i(frm_ready_i),
    .frm_ide_o(frm_ide_o), .frm_rtr_o(frm_rtr_o), .frm_id_o(frm_id_o),
    .frm_dlc_o(frm_dlc_o), .frm_data_o(frm_data_o),
    .ir_valid_o(ir_valid_o), .ir_value_o(ir_value_o),
    .err_o(err_o), .err_clr_i(err_clr_i)
  );

  int checks_r = 0;
  int errors_r = 0;

  logic [7:0]   mem [0:255];
  logic [7:0]   ir_q [$];
  logic [103:0] bufq [$];
  logic [20:0]  exp_apb [$];
  logic [7:0]   exp_ir [$];
  logic [98:0]  exp_frm [$];
  int           wait_states = 0;
  int           wcnt = 0;
  int           err_idx = -1;

  localparam logic [98:0] FRM_SFF  = {1'b0, 1'b0, 29'h52B, 4'h2, 64'h2211};
  localparam logic [98:0] FRM_EFF  = {1'b1, 1'b1, 29'h02468ACF, 4'h8, 64'h0};
  localparam logic [98:0] FRM_CLMP = {1'b0, 1'b0, 29'h401, 4'hF, 64'h0807060504030201};
  localparam logic [98:0] FRM_A    = {1'b0, 1'b0, 29'h097, 4'h1, 64'hAB};
  localparam logic [98:0] FRM_B    = {1'b0, 1'b0, 29'h7F8, 4'h0, 64'h0};

  // Clock generation.
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog sim time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks_r++;
    if (got !== exp) begin
      errors_r++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [20:0] apb_rd(input int idx);
    logic [7:0] i8;
    i8 = idx[7:0];
    return {1'b0, 4'b0000, i8, 8'h00};
  endfunction

  task automatic push_rds(input int first, input int n);
    for (int i = 0; i < n; i++) exp_apb.push_back(apb_rd(first + i));
  endtask

  task automatic push_rrb();
    exp_apb.push_back({1'b1, 4'b0001, 8'd1, 8'h04});
  endtask

  task automatic load_img(input logic [103:0] img);
    for (int k = 0; k < 13; k++) mem[16 + k] = img[8*k +: 8];
  endtask

  // APB slave model with transfer scoreboard; decides pready on negedge.
  always @(negedge aclk) begin
    int idx;
    logic [20:0] obs;
    if (m_apb_psel && m_apb_penable) begin
      if (wcnt < wait_states) begin
        m_apb_pready = 1'b0;
        wcnt++;
      end else begin
        idx = int'(m_apb_paddr[9:2]);
        m_apb_pready  = 1'b1;
        m_apb_pslverr = (idx == err_idx);
        if (m_apb_pwrite) begin
          m_apb_prdata = 32'd0;
          if (idx == 1 && m_apb_pwdata[7:0] == 8'h04 && bufq.size() > 0) load_img(bufq.pop_front());
        end else if (idx == 3) begin
          m_apb_prdata = {24'd0, (ir_q.size() > 0) ? ir_q.pop_front() : 8'h00};
          if (!m_apb_pslverr) exp_ir.push_back(m_apb_prdata[7:0]);
        end else begin
          m_apb_prdata = {24'd0, mem[idx]};
        end
        obs = {m_apb_pwrite, m_apb_pstrb, m_apb_paddr[9:2],
               m_apb_pwrite ? m_apb_pwdata[7:0] : 8'h00};
        if (exp_apb.size() == 0) check_eq("apb_pending", 128'(exp_apb.size() != 0), 128'd1);
        else check_eq("apb_xfer", 128'(obs), 128'(exp_apb.pop_front()));
      end
    end else begin
      m_apb_pready  = 1'b0;
      m_apb_pslverr = 1'b0;
      wcnt = 0;
    end
  end

  // IR pulse and accepted-frame scoreboards.
  always @(negedge aclk) begin
    if (arstn && ir_valid_o) begin
      if (exp_ir.size() == 0) check_eq("ir_pending", 128'(exp_ir.size() != 0), 128'd1);
      else check_eq("ir_value", 128'(ir_value_o), 128'(exp_ir.pop_front()));
    end
    if (arstn && frm_valid_o && frm_ready_i) begin
      if (exp_frm.size() == 0) check_eq("frm_pending", 128'(exp_frm.size() != 0), 128'd1);
      else check_eq("frame", 128'({frm_ide_o, frm_rtr_o, frm_id_o, frm_dlc_o, frm_data_o}),
                    128'(exp_frm.pop_front()));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic pulse_irq();
    irq_i = 1'b1;
    step(1);
    irq_i = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_apb.size() != 0 || exp_frm.size() != 0 || m_apb_psel) && n < budget) begin
      step(1);
      n++;
    end
    step(4);
    check_eq({tag, "_drained"}, 128'(exp_apb.size() + exp_frm.size()), 128'd0);
  endtask

  initial begin
    int n;
    arstn = 1'b0; enable_i = 1'b1; irq_i = 1'b0; frm_ready_i = 1'b1; err_clr_i = 1'b0;
    m_apb_prdata = 32'd0; m_apb_pready = 1'b0; m_apb_pslverr = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    step(3);
    check_eq("reset_apb", 128'({m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_paddr,
                                m_apb_pwdata, m_apb_pstrb, m_apb_pprot}), 128'd0);
    check_eq("reset_frm", 128'({frm_valid_o, frm_ide_o, frm_rtr_o, frm_id_o, frm_dlc_o,
                                frm_data_o, ir_valid_o, ir_value_o, err_o}), 128'd0);
    arstn = 1'b1;
    step(2);

    // SFF data frame, then IR=0 returns to idle.
    load_img(104'h22_11_60_A5_02);
    ir_q.push_back(8'h01); ir_q.push_back(8'h00);
    push_rds(3, 1); push_rds(16, 5); push_rrb(); push_rds(3, 1);
    exp_frm.push_back(FRM_SFF);
    pulse_irq();
    wait_drain("sff", 200);
    check_eq("sff_irval", 128'(ir_value_o), 128'h00);

    // EFF remote frame: no data reads.
    load_img(104'h78_56_34_12_C8);
    ir_q.push_back(8'h01); ir_q.push_back(8'h00);
    push_rds(3, 1); push_rds(16, 5); push_rrb(); push_rds(3, 1);
    exp_frm.push_back(FRM_EFF);
    pulse_irq();
    wait_drain("eff", 200);

    // DLC clamp: DLC 15 reads exactly 8 data bytes.
    load_img(104'h08_07_06_05_04_03_02_01_20_80_0F);
    ir_q.push_back(8'h01); ir_q.push_back(8'h00);
    push_rds(3, 1); push_rds(16, 11); push_rrb(); push_rds(3, 1);
    exp_frm.push_back(FRM_CLMP);
    pulse_irq();
    wait_drain("clamp", 300);

    // Drain disabled: irq ignored.
    enable_i = 1'b0;
    pulse_irq();
    step(5);
    check_eq("disabled_idle", 128'(m_apb_psel), 128'd0);
    enable_i = 1'b1;

    // Backpressure and a queued second frame.
    load_img(104'hAB_E0_12_01);
    bufq.push_back(104'h1F_FF_00);
    ir_q.push_back(8'h01); ir_q.push_back(8'h01); ir_q.push_back(8'h00);
    push_rds(3, 1); push_rds(16, 4); push_rrb();
    push_rds(3, 1); push_rds(16, 3); push_rrb(); push_rds(3, 1);
    exp_frm.push_back(FRM_A); exp_frm.push_back(FRM_B);
    frm_ready_i = 1'b0;
    pulse_irq();
    n = 0;
    while (!frm_valid_o && n < 200) begin step(1); n++; end
    for (int i = 0; i < 20; i++) begin
      check_eq("bp_hold", 128'({frm_valid_o, m_apb_psel, frm_ide_o, frm_rtr_o, frm_id_o,
                                frm_dlc_o, frm_data_o}), 128'({1'b1, 1'b0, FRM_A}));
      step(1);
    end
    frm_ready_i = 1'b1;
    wait_drain("queued", 300);

    // Slave error on the second ID byte: no release, error flag, idle.
    load_img(104'h22_11_60_A5_02);
    ir_q.push_back(8'h01);
    err_idx = 18;
    push_rds(3, 1); push_rds(16, 3);
    pulse_irq();
    wait_drain("slverr", 200);
    err_idx = -1;
    check_eq("slverr_err", 128'(err_o), 128'd1);
    step(5);
    check_eq("slverr_idle", 128'({m_apb_psel, frm_valid_o, err_o}), 128'b001);
    err_clr_i = 1'b1;
    step(1);
    err_clr_i = 1'b0;
    check_eq("err_clear", 128'(err_o), 128'd0);

`ifdef CAN_DRAIN_TIMEOUT_EN
    // pready held low: abort after 10 access cycles.
    wait_states = 100000;
    pulse_irq();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_apb_psel && m_apb_penable) n++;
      step(1);
    end
    check_eq("tmo_len", 128'(n), 128'd10);
    check_eq("tmo_err", 128'({m_apb_psel, err_o}), 128'b01);
    wait_states = 0;
    err_clr_i = 1'b1;
    step(1);
    err_clr_i = 1'b0;
`endif

    // Reset during the ACCESS phase of the first data read.
    load_img(104'h22_11_60_A5_02);
    ir_q.push_back(8'h01);
    wait_states = 3;
    push_rds(3, 1); push_rds(16, 3);
    pulse_irq();
    n = 0;
    while (!(m_apb_psel && m_apb_penable && m_apb_paddr == 32'h4C) && n < 300) begin
      step(1);
      n++;
    end
    check_eq("rst_reach", 128'(m_apb_paddr), 128'h4C);
    #2;
    arstn = 1'b0;
    #1;
    check_eq("rst_async", 128'({m_apb_psel, m_apb_penable, frm_valid_o}), 128'd0);
    check_eq("rst_xfers", 128'(exp_apb.size()), 128'd0);
    wait_states = 0;
    step(2);
    arstn = 1'b1;
    step(3);
    check_eq("rst_idle", 128'(m_apb_psel), 128'd0);
    ir_q.delete();
    ir_q.push_back(8'h01); ir_q.push_back(8'h00);
    push_rds(3, 1); push_rds(16, 5); push_rrb(); push_rds(3, 1);
    exp_frm.push_back(FRM_SFF);
    pulse_irq();
    wait_drain("restart", 200);

    check_eq("end_queues", 128'(exp_ir.size() + exp_frm.size() + exp_apb.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
    $finish;
  end

endmodule

// File: doc/can_rx_drain.md
Name: can_rx_drain

Overview:
- APB master that sits directly downstream of the sja1000 controller wrapper.
- Consumes its active-high irq and drives its APB slave port.
- On a receive interrupt it reads the PeliCAN receive buffer, releases the buffer (RRB), and presents the frame on a valid/ready stream.
- Software no longer has to service RX interrupts byte by byte.

Parameters:
- BASE_ADDR, 32'h0000_0000, APB address of controller register 0; register n is at BASE_ADDR + (n << 2).
- CMD_REG, 1, command register index; RRB is bit 2.
- IR_REG, 3, interrupt register index; RI is bit 0.
- RXBUF_REG, 16, index of frame-information byte; ID/data bytes follow consecutively.
- TIMEOUT_CYCLES, 255, pready wait limit; used only with CAN_DRAIN_TIMEOUT_EN.

Ports:
- aclk  in  1  clock
- arstn  in  1  asynchronous active-low reset
- enable_i  in  1  drain enable
- irq_i  in  1  controller interrupt, active high, level
- m_apb_paddr  out  32  APB address
- m_apb_psel  out  1  APB select
- m_apb_penable  out  1  APB enable
- m_apb_pwrite  out  1  APB write
- m_apb_pwdata  out  32  APB write data
- m_apb_pstrb  out  4  APB strobe
- m_apb_pprot  out  3  APB protection, constant 3'b000
- m_apb_prdata  in  32  APB read data; bits [7:0] used
- m_apb_pready  in  1  APB ready
- m_apb_pslverr  in  1  APB slave error
- frm_valid_o  out  1  frame valid
- frm_ready_i  in  1  frame accepted
- frm_ide_o  out  1  extended frame
- frm_rtr_o  out  1  remote frame
- frm_id_o  out  29  identifier, right-aligned
- frm_dlc_o  out  4  raw DLC from frame info
- frm_data_o  out  64  data; byte k at [8k+7:8k]; unused bytes zero
- ir_valid_o  out  1  one-cycle pulse; the IR value was just read
- ir_value_o  out  8  last IR byte read (non-RI interrupt bits are cleared by the read)
- err_o  out  1  sticky error flag
- err_clr_i  in  1  clears err_o

Behaviour:
- Reset: clock aclk, reset arstn, asynchronous active-low.
  - While arstn is low, all outputs are 0 and the FSM is IDLE.
  - Assertion mid-transfer abandons the APB cycle immediately (psel/penable drop asynchronously).
- APB transfer, one per step, 2 cycles minimum:
  - SETUP: psel=1, penable=0.
  - ACCESS: penable=1, held until pready=1. Read data is captured on pready.
  - psel and penable are deasserted for one cycle between transfers.
  - Writes use pwdata = {24'h0, byte} and pstrb = 4'b0001. Reads use pstrb = 0.
- FSM states and transitions:
  - IDLE: go to RD_IR when irq_i & enable_i.
  - RD_IR: read IR_REG; pulse ir_valid_o and update ir_value_o.
    - If RI=1, go to RD_FI.
    - If RI=0, go to IDLE.
  - RD_FI: read RXBUF_REG and latch FF (bit 7) to ide, RTR (bit 6) to rtr, and bits [3:0] to dlc.
    - The number of data bytes is nb = rtr ? 0 : min(dlc, 8).
  - RD_ID: ide=0 reads 2 bytes; ide=1 reads 4 bytes.
    - SFF: id[10:3] = b0, id[2:0] = b1[7:5], upper id bits zero.
    - EFF: id[28:21] = b0, [20:13] = b1, [12:5] = b2, [4:0] = b3[7:3].
  - RD_DATA: read nb bytes starting at RXBUF_REG+3 (SFF) or RXBUF_REG+5 (EFF).
    - Skipped when nb = 0.
    - frm_data_o is zeroed on entry to RD_FI.
  - WR_CMD: write 8'h04 to CMD_REG (RRB).
  - OUT: frm_valid_o=1; frame outputs stay stable until frm_ready_i.
    - On valid & ready, go to RD_IR to drain queued messages.
- Sequencing rules:
  - enable_i low is sampled only in IDLE; a frame in progress always completes.
  - irq_i is ignored outside IDLE.
  - pslverr=1 on any transfer:
    - err_o is set and the FSM goes to IDLE.
    - No frame is emitted; a partially read buffer is not released.
  - err_clr_i clears err_o. An error in the same cycle as err_clr_i wins (err_o=1).
- Minimum latency with zero wait states: SFF with DLC=2 takes 7 transfers = 14 cycles (plus gaps) from irq_i to frm_valid_o.

Optional Feature:
- Macro CAN_DRAIN_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter counts ACCESS cycles with pready=0.
  - Reaching TIMEOUT_CYCLES drops psel/penable, sets err_o, and returns to IDLE, handled exactly as pslverr.
  - The counter clears at each SETUP.
- Not defined: the block waits on pready indefinitely and the counter is absent.

Test Plan:
- SFF data frame:
  - Slave returns IR=8'h01, FI=8'h02, ID1=8'hA5, ID2=8'h60, data 8'h11, 8'h22.
  - Required: exactly 6 reads at register indices 3, 16, 17, 18, 19, 20, then a write of 8'h04 to index 1.
  - Then frm_id=29'h52B, ide=0, rtr=0, dlc=2, data=64'h2211.
  - After accept, IR is re-read; IR=8'h00 returns the FSM to IDLE.
- EFF remote frame:
  - FI=8'hC8, ID bytes 8'h12, 8'h34, 8'h56, 8'h78.
  - Required: no data reads, frm_id=29'h02468ACF, ide=1, rtr=1, dlc=8, data=0.
- DLC clamp: FI=8'h0F (SFF) -> exactly 8 data reads (indices 19..26), dlc output 4'hF.
- Backpressure and queued frames:
  - Hold frm_ready_i=0 for 20 cycles.
  - Required: outputs stable, no APB activity.
  - Second IR read returns 8'h01 -> second frame drained with no new irq edge.
- Errors: pslverr on the ID2 read -> err_o=1, no RRB write, FSM IDLE; err_clr_i clears err_o. With CAN_DRAIN_TIMEOUT_EN and TIMEOUT_CYCLES=10, pready held low -> abort after 10 cycles, err_o=1.
- Reset mid-read: arstn low during the ACCESS phase of a data read -> psel, penable and frm_valid_o are 0 that same cycle; after release the FSM is IDLE and restarts on irq_i.
